int_controller: RTL and testbench
=================================

// Module: int_controller
// PURPOSE
//  Prioritised interrupt controller for the CPU. Latches rising edges on N_IRQ peripheral lines and arbitrates them by fixed priority.
//  Raises cpu_int to the control unit and supplies the handler vector on the int_ack handshake (driven by io_ints).
//  Tracks the in-service source until end-of-interrupt (eoi, driven by io_read_retaddr).
//  Mask, pending and vector-base registers are reachable over the IO interface (io_read/io_write, io_addr, d_bus).
// PARAMETERS
//  N_IRQ      8        number of interrupt sources, 1..16; index 0 = highest priority
//  ADDR_MASK  4'hC     io_addr of MASK register (R/W, 1 = enabled)
//  ADDR_PEND  4'hD     io_addr of PENDING register (R, write-1-to-clear)
//  ADDR_VBASE 4'hE     io_addr of VECBASE register (R/W)
//  ADDR_ISR   4'hF     io_addr of in-service register (R only; writes ignored)
// PORTS
//  clk         in   1      system clock, all state on rising edge
//  rst         in   1      synchronous reset, active-high
//  irq_in      in   N_IRQ  peripheral requests, already synchronous to clk
//  io_read     in   1      IO read strobe
//  io_write    in   1      IO write strobe
//  io_addr     in   4      IO register address
//  d_in        in   16     write data (from d_bus)
//  d_out       out  16     read data (to d_bus when d_out_en)
//  d_out_en    out  1      d_bus drive enable
//  cpu_int     out  1      interrupt request to control unit
//  int_ack     in   1      one-cycle acknowledge from control unit (io_ints)
//  eoi         in   1      one-cycle end-of-interrupt (io_read_retaddr)
//  int_vector  out  16     handler address
// BEHAVIOUR
//  Reset: pending=0, mask=0, vbase=16'h0000, isr=0, irq_q=0, state=IDLE, cpu_int=0, int_vector=0, d_out_en=0.
//  Edge detect: pending[i] set at posedge where irq_in[i]=1 and irq_q[i]=0; set regardless of mask.
//   Level held high does not re-set; a second edge while pending is absorbed (no counting).
//  Requests: req = pending & mask. Winner = lowest set index of req (combinational).
//  FSM (state registered; cpu_int = (state==REQ), registered):
//   IDLE    : req!=0 -> REQ; latch win_id, int_vector <= vbase + {win_id,2'b00} (16-bit wrap).
//   REQ     : int_ack -> SVC; clear pending[win_id], set isr[win_id].
//             mask[win_id] or pending[win_id] cleared by IO write before ack -> IDLE (request withdrawn).
//             A higher-priority arrival in REQ does not pre-empt; win_id and int_vector stay frozen.
//   SVC     : eoi -> IDLE, isr cleared. No nesting: new requests only pend.
//  Latency: irq edge sampled at posedge k -> pending at k -> cpu_int high after posedge k+1.
//   After eoi, next request reaches cpu_int 2 cycles later (IDLE arbitration cycle, then REQ).
//  int_ack outside REQ and eoi outside SVC are ignored (no state change).
//  Simultaneous same-cycle edge and clear on the same bit (ack clear or W1C): set wins; bit stays pending.
//  int_vector held stable from REQ entry until next IDLE->REQ; isr reads one-hot of win_id in SVC, else 0.
//  IO reads: combinational; d_out_en = io_read & addr in {MASK,PEND,VBASE,ISR}, else d_out=0.
//   Register fields zero-extended to 16 bits.
//  IO writes: take effect at posedge with io_write; mask bits >= N_IRQ ignored.
//  io_read and io_write in the same cycle: write occurs; read returns pre-write value.
//  rst mid-handshake: returns to IDLE, cpu_int low next cycle, all pending lost.
// STRUCTURE
//  Shared header io_defs.vh: IO register address constants and FSM state encodings (IDLE=2'd0, REQ=2'd1, SVC=2'd2).
//  One sub-module: irq_priority_enc (N_IRQ-wide find-first-set -> id + valid, pure combinational).
//  Top holds the edge regs, pending/mask/vbase/isr regs, FSM and IO decode.
// TESTING
//  1. Reset, write MASK=8'h04, VBASE=16'h0100, pulse irq_in[2] -> cpu_int high 2 cycles later, int_vector=16'h0108.
//     Then int_ack -> cpu_int low, ISR reads 16'h0004, PEND reads 0.
//  2. irq_in[5] and irq_in[1] rise together, MASK=8'hFF -> vector for 1 first.
//     After eoi, cpu_int re-asserts 2 cycles later with vector for 5.
//  3. In REQ for id 3, write MASK=0 -> cpu_int drops the next cycle, state IDLE, PEND still 16'h0008.
//     Then write PEND=16'h0008 -> PEND reads 0.
//  4. irq_in[0] held high 20 cycles across ack/eoi -> exactly one interrupt. Edge during ack cycle -> bit re-pends, second interrupt.
//  5. VBASE=16'hFFFC, irq 1 -> int_vector=16'h0000 (wrap). Spurious int_ack in IDLE and eoi in REQ -> no state change.
//  6. Assert rst while in SVC -> all outputs at reset values next cycle; no interrupt raised with irq_in held high.

Source files
------------

// File: rtl/int_controller_pkg.sv
// Shared definitions for the interrupt controller: IO register map, FSM encoding
// and the width of a source id.
package int_controller_pkg;

    localparam logic [3:0] DEF_ADDR_MASK  = 4'hC;
    localparam logic [3:0] DEF_ADDR_PEND  = 4'hD;
    localparam logic [3:0] DEF_ADDR_VBASE = 4'hE;
    localparam logic [3:0] DEF_ADDR_ISR   = 4'hF;

    // Wide enough for up to 16 sources.
    localparam int ID_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        SVC  = 2'd2
    } state_t;

endpackage

// File: rtl/int_controller_priority_enc.sv
// Fixed-priority find-first-set: reports the lowest set index of req and whether
// any bit is set. Purely combinational.
module irq_priority_enc
    import int_controller_pkg::*;
#(
    parameter int N_IRQ = 8
) (
    input  logic [N_IRQ-1:0] req,
    output logic [ID_W-1:0]  id,
    output logic             valid
);

    // NOTE: every output of an always_comb gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        id = '0;
        // Scan from the top down so the lowest set index is the last one written.
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                id = ID_W'(i);
            end
        end
    end

    assign valid = |req;

endmodule

// File: rtl/int_controller.sv
// Prioritised interrupt controller: edge-latches peripheral requests, raises cpu_int
// for the highest-priority enabled source, and tracks it in service until eoi.
module int_controller
    import int_controller_pkg::*;
#(
    parameter int         N_IRQ      = 8,
    parameter logic [3:0] ADDR_MASK  = DEF_ADDR_MASK,
    parameter logic [3:0] ADDR_PEND  = DEF_ADDR_PEND,
    parameter logic [3:0] ADDR_VBASE = DEF_ADDR_VBASE,
    parameter logic [3:0] ADDR_ISR   = DEF_ADDR_ISR
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_IRQ-1:0] irq_in,
    input  logic             io_read,
    input  logic             io_write,
    input  logic [3:0]       io_addr,
    input  logic [15:0]      d_in,
    output logic [15:0]      d_out,
    output logic             d_out_en,
    output logic             cpu_int,
    input  logic             int_ack,
    input  logic             eoi,
    output logic [15:0]      int_vector
);

    state_t state, state_n;

    logic [N_IRQ-1:0] irq_q, pending, mask, isr;
    logic [N_IRQ-1:0] pending_n, mask_n, pend_set, pend_clr, req, win_oh;
    logic [15:0]      vbase;
    logic [ID_W-1:0]  win_id, enc_id;
    logic             enc_valid, ack_fire, eoi_fire, take;
    logic             wr_mask, wr_pend, wr_vbase;

    assign wr_mask  = io_write && (io_addr == ADDR_MASK);
    assign wr_pend  = io_write && (io_addr == ADDR_PEND);
    assign wr_vbase = io_write && (io_addr == ADDR_VBASE);

    assign req = pending & mask;

    irq_priority_enc #(.N_IRQ(N_IRQ)) u_enc (
        .req   (req),
        .id    (enc_id),
        .valid (enc_valid)
    );

    assign win_oh   = N_IRQ'(1) << win_id;
    assign ack_fire = (state == REQ) && int_ack;
    assign eoi_fire = (state == SVC) && eoi;
    assign cpu_int  = (state == REQ);

    // Clears are applied before sets so a same-cycle edge keeps the bit pending.
    assign pend_set = irq_in & ~irq_q;
    always_comb begin
        pend_clr = '0;
        if (ack_fire) pend_clr = pend_clr | win_oh;
        if (wr_pend)  pend_clr = pend_clr | d_in[N_IRQ-1:0];
    end
    assign pending_n = (pending & ~pend_clr) | pend_set;
    assign mask_n    = wr_mask ? d_in[N_IRQ-1:0] : mask;

    always_comb begin
        state_n = state;
        take    = 1'b0;
        unique case (state)
            IDLE: begin
                if (enc_valid) begin
                    state_n = REQ;
                    take    = 1'b1;
                end
            end
            REQ: begin
                // Ack takes precedence over a withdrawal written in the same cycle.
                if (int_ack) begin
                    state_n = SVC;
                end else if (!(|(win_oh & mask_n & pending_n))) begin
                    state_n = IDLE;
                end
            end
            SVC: begin
                if (eoi) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            irq_q      <= '0;
            pending    <= '0;
            mask       <= '0;
            vbase      <= '0;
            isr        <= '0;
            win_id     <= '0;
            int_vector <= '0;
        end else begin
            irq_q   <= irq_in;
            pending <= pending_n;
            mask    <= mask_n;
            if (wr_vbase) vbase <= d_in;
            if (take) begin
                win_id     <= enc_id;
                int_vector <= vbase + 16'({enc_id, 2'b00});
            end
            if (ack_fire)      isr <= win_oh;
            else if (eoi_fire) isr <= '0;
        end
    end

    // Reads are combinational from the registers, so a same-cycle write is not visible.
    always_comb begin
        d_out    = '0;
        d_out_en = 1'b0;
        if (io_read) begin
            if (io_addr == ADDR_MASK) begin
                d_out    = 16'(mask);
                d_out_en = 1'b1;
            end else if (io_addr == ADDR_PEND) begin
                d_out    = 16'(pending);
                d_out_en = 1'b1;
            end else if (io_addr == ADDR_VBASE) begin
                d_out    = vbase;
                d_out_en = 1'b1;
            end else if (io_addr == ADDR_ISR) begin
                d_out    = 16'(isr);
                d_out_en = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_int_controller.sv
// Directed bench for int_controller: a vector table for the main flows plus
// hand-written sequences for withdrawal, held levels, edge/clear races and reset.
module tb_int_controller;

    localparam logic [3:0] A_MASK  = 4'hC;
    localparam logic [3:0] A_PEND  = 4'hD;
    localparam logic [3:0] A_VBASE = 4'hE;
    localparam logic [3:0] A_ISR   = 4'hF;
    localparam logic [3:0] A_NONE  = 4'h3;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  irq_in;
    logic        io_read, io_write;
    logic [3:0]  io_addr;
    logic [15:0] d_in;
    logic [15:0] d_out;
    logic        d_out_en;
    logic        cpu_int;
    logic        int_ack, eoi;
    logic [15:0] int_vector;

    int checks   = 0;
    int failures = 0;

    int_controller dut (
        .clk        (clk),
        .rst        (rst),
        .irq_in     (irq_in),
        .io_read    (io_read),
        .io_write   (io_write),
        .io_addr    (io_addr),
        .d_in       (d_in),
        .d_out      (d_out),
        .d_out_en   (d_out_en),
        .cpu_int    (cpu_int),
        .int_ack    (int_ack),
        .eoi        (eoi),
        .int_vector (int_vector)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        rd;
        logic        wr;
        logic [3:0]  addr;
        logic [15:0] din;
        logic [7:0]  irq;
        logic        ack;
        logic        eoi;
        logic [15:0] exp_dout;
        logic        exp_doen;
        logic        exp_int;
        logic [15:0] exp_vec;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input string n, input logic rd, input logic wr, input logic [3:0] a,
                       input logic [15:0] din, input logic [7:0] irq, input logic ack,
                       input logic e, input logic [15:0] xd, input logic xen,
                       input logic xint, input logic [15:0] xvec);
        vec_t v;
        v.name = n; v.rd = rd; v.wr = wr; v.addr = a; v.din = din; v.irq = irq;
        v.ack = ack; v.eoi = e; v.exp_dout = xd; v.exp_doen = xen;
        v.exp_int = xint; v.exp_vec = xvec;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        io_read = 1'b0; io_write = 1'b0; io_addr = A_NONE; d_in = '0;
        int_ack = 1'b0; eoi = 1'b0;
    endtask

    task automatic io_wr(input logic [3:0] a, input logic [15:0] data);
        io_write = 1'b1; io_addr = a; d_in = data;
        tick();
        io_write = 1'b0; io_addr = A_NONE; d_in = '0;
    endtask

    task automatic io_rd(input string name, input logic [3:0] a, input logic [15:0] exp);
        io_read = 1'b1; io_addr = a;
        #1;
        check({name, " data"}, d_out, exp);
        check({name, " en"}, 16'(d_out_en), 16'd1);
        io_read = 1'b0; io_addr = A_NONE;
    endtask

    task automatic wait_int(input string name, input int budget);
        int n = 0;
        while (!cpu_int && n < budget) begin
            tick();
            n++;
        end
        check(name, 16'(cpu_int), 16'd1);
    endtask

    initial begin
        int highs;

        rst = 1'b1; irq_in = '0; idle_inputs();
        tick(); tick();
        check("reset cpu_int", 16'(cpu_int), 16'd0);
        check("reset vector", int_vector, 16'h0000);
        check("reset d_out_en", 16'(d_out_en), 16'd0);
        rst = 1'b0;

        //  name           rd  wr  addr     din      irq    ack eoi dout     en int vec
        add("t1 wmask",    0,  1,  A_MASK,  16'h0004, 8'h00, 0, 0, 16'h0000, 0, 0, 16'h0000);
        add("t1 wvbase",   0,  1,  A_VBASE, 16'h0100, 8'h00, 0, 0, 16'h0000, 0, 0, 16'h0000);
        add("t1 edge2",    1,  0,  A_MASK,  16'h0000, 8'h04, 0, 0, 16'h0004, 1, 0, 16'h0000);
        add("t1 req",      1,  0,  A_PEND,  16'h0000, 8'h00, 0, 0, 16'h0004, 1, 1, 16'h0108);
        add("t1 hold",     1,  0,  A_VBASE, 16'h0000, 8'h00, 0, 0, 16'h0100, 1, 1, 16'h0108);
        add("t1 ack",      1,  0,  A_ISR,   16'h0000, 8'h00, 1, 0, 16'h0000, 1, 0, 16'h0108);
        add("t1 isr",      1,  0,  A_ISR,   16'h0000, 8'h00, 0, 0, 16'h0004, 1, 0, 16'h0108);
        add("t1 pend0",    1,  0,  A_PEND,  16'h0000, 8'h00, 0, 0, 16'h0000, 1, 0, 16'h0108);
        add("t1 eoi",      1,  0,  A_NONE,  16'h0000, 8'h00, 0, 1, 16'h0000, 0, 0, 16'h0108);
        add("t1 idle",     0,  0,  A_NONE,  16'h0000, 8'h00, 0, 0, 16'h0000, 0, 0, 16'h0108);
        add("t2 edges",    0,  1,  A_MASK,  16'h00FF, 8'h22, 0, 0, 16'h0000, 0, 0, 16'h0108);
        add("t2 req1",     1,  0,  A_PEND,  16'h0000, 8'h22, 0, 0, 16'h0022, 1, 1, 16'h0104);
        add("t2 ack1",     0,  0,  A_NONE,  16'h0000, 8'h00, 1, 0, 16'h0000, 0, 0, 16'h0104);
        add("t2 isr1",     1,  0,  A_ISR,   16'h0000, 8'h00, 0, 0, 16'h0002, 1, 0, 16'h0104);
        add("t2 eoi1",     0,  0,  A_NONE,  16'h0000, 8'h00, 0, 1, 16'h0000, 0, 0, 16'h0104);
        add("t2 req5",     0,  0,  A_NONE,  16'h0000, 8'h00, 0, 0, 16'h0000, 0, 1, 16'h0114);
        add("t2 ack5",     0,  0,  A_NONE,  16'h0000, 8'h00, 1, 0, 16'h0000, 0, 0, 16'h0114);
        add("t2 eoi5",     1,  0,  A_PEND,  16'h0000, 8'h00, 0, 1, 16'h0000, 1, 0, 16'h0114);
        add("t5 wvbase",   0,  1,  A_VBASE, 16'hFFFC, 8'h00, 0, 0, 16'h0000, 0, 0, 16'h0114);
        add("t5 edge1",    0,  0,  A_NONE,  16'h0000, 8'h02, 0, 0, 16'h0000, 0, 0, 16'h0114);
        add("t5 wrap",     0,  0,  A_NONE,  16'h0000, 8'h00, 0, 0, 16'h0000, 0, 1, 16'h0000);
        add("t5 eoi@req",  1,  0,  A_ISR,   16'h0000, 8'h00, 0, 1, 16'h0000, 1, 1, 16'h0000);
        add("t5 ack",      0,  0,  A_NONE,  16'h0000, 8'h00, 1, 0, 16'h0000, 0, 0, 16'h0000);
        add("t5 eoi",      0,  0,  A_NONE,  16'h0000, 8'h00, 0, 1, 16'h0000, 0, 0, 16'h0000);
        add("t5 ack@idle", 1,  0,  A_ISR,   16'h0000, 8'h00, 1, 0, 16'h0000, 1, 0, 16'h0000);

        foreach (vecs[i]) begin
            io_read = vecs[i].rd; io_write = vecs[i].wr; io_addr = vecs[i].addr;
            d_in = vecs[i].din; irq_in = vecs[i].irq;
            int_ack = vecs[i].ack; eoi = vecs[i].eoi;
            #1;
            check({vecs[i].name, " d_out"}, d_out, vecs[i].exp_dout);
            check({vecs[i].name, " d_out_en"}, 16'(d_out_en), 16'(vecs[i].exp_doen));
            tick();
            check({vecs[i].name, " cpu_int"}, 16'(cpu_int), 16'(vecs[i].exp_int));
            check({vecs[i].name, " vector"}, int_vector, vecs[i].exp_vec);
        end
        idle_inputs(); irq_in = '0;

        // Withdrawal by masking while in REQ, then W1C of the stranded bit.
        io_wr(A_MASK, 16'h0008);
        irq_in = 8'h08; tick(); irq_in = '0;
        wait_int("t3 req3", 4);
        check("t3 vector", int_vector, 16'h0008);
        io_wr(A_MASK, 16'h0000);
        check("t3 withdrawn", 16'(cpu_int), 16'd0);
        io_rd("t3 pend kept", A_PEND, 16'h0008);
        tick(); tick();
        check("t3 stays idle", 16'(cpu_int), 16'd0);
        io_wr(A_PEND, 16'h0008);
        io_rd("t3 pend w1c", A_PEND, 16'h0000);

        // Level held high across ack/eoi yields a single interrupt.
        io_wr(A_MASK, 16'h0001);
        irq_in = 8'h01; tick();
        wait_int("t4 level req", 4);
        int_ack = 1'b1; tick(); int_ack = 1'b0;
        check("t4 acked", 16'(cpu_int), 16'd0);
        tick(); tick();
        eoi = 1'b1; tick(); eoi = 1'b0;
        highs = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (cpu_int) highs++;
        end
        check("t4 no repeat", 16'(highs), 16'd0);
        irq_in = '0; tick();

        // Edge in the ack cycle re-pends the same bit.
        irq_in = 8'h01; tick(); irq_in = '0;
        tick();
        check("t4 req again", 16'(cpu_int), 16'd1);
        int_ack = 1'b1; irq_in = 8'h01; tick(); int_ack = 1'b0; irq_in = '0;
        check("t4 svc", 16'(cpu_int), 16'd0);
        io_rd("t4 repend", A_PEND, 16'h0001);
        io_rd("t4 isr", A_ISR, 16'h0001);
        eoi = 1'b1; tick(); eoi = 1'b0;
        tick();
        check("t4 second int", 16'(cpu_int), 16'd1);
        int_ack = 1'b1; tick(); int_ack = 1'b0;
        eoi = 1'b1; tick(); eoi = 1'b0;

        // Edge and W1C on the same bit in one cycle: the edge wins.
        io_write = 1'b1; io_addr = A_PEND; d_in = 16'h0001; irq_in = 8'h01;
        tick();
        io_write = 1'b0; io_addr = A_NONE; d_in = '0; irq_in = '0;
        io_rd("t4 w1c race", A_PEND, 16'h0001);
        wait_int("t6 req", 4);
        int_ack = 1'b1; tick(); int_ack = 1'b0;

        // Reset while in service, with a level held high afterwards.
        irq_in = 8'hFF; rst = 1'b1;
        tick();
        check("t6 rst cpu_int", 16'(cpu_int), 16'd0);
        check("t6 rst vector", int_vector, 16'h0000);
        check("t6 rst d_out_en", 16'(d_out_en), 16'd0);
        rst = 1'b0;
        highs = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (cpu_int) highs++;
        end
        check("t6 no int", 16'(highs), 16'd0);
        io_rd("t6 mask", A_MASK, 16'h0000);
        io_rd("t6 vbase", A_VBASE, 16'h0000);
        io_rd("t6 isr", A_ISR, 16'h0000);
        irq_in = '0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
